// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: multi-cycle unsigned shift-add multiplier that borrows the
// shared EX-stage ALU adder. One add-and-shift step per cycle for WIDTH cycles,
// with the 2*WIDTH product accumulated in hi/lo. The pipeline stalls on busy.
module alu_mul_sequencer #(
    parameter int         WIDTH   = 32,
    parameter logic [1:0] SEL_AND = 2'b00,
    parameter logic [1:0] SEL_ADD = 2'b10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic [1:0]       alu_sel,
    output logic             alu_invert_b,
    output logic             alu_cin,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mcandReg;
    logic             calcActive;

    assign calcActive = (state == CALC);

    // ALU steering: add hi + (lo[0] ? mcand : 0) while iterating, quiescent otherwise
    assign alu_sel      = calcActive ? SEL_ADD : SEL_AND;
    assign alu_invert_b = 1'b0;
    assign alu_cin      = 1'b0;
    assign alu_a        = calcActive ? hi : '0;
    assign alu_b        = (calcActive && lo[0]) ? mcandReg : '0;

    // Sequencer FSM with the product accumulator and registered busy/done flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            mcandReg <= '0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= CALC;
                        mcandReg <= mcand;
                        hi       <= '0;
                        lo       <= mplier;
                        count    <= '0;
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    // The adder carry becomes the new MSB of hi; the retired
                    // multiplier bit falls off the bottom of lo.
                    {hi, lo} <= {alu_cout, alu_result, lo[WIDTH-1:1]};
                    count    <= count + 1'b1;
                    if (count == LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
